uart_frame_assembler: RTL and testbench

//  Parametrised successor of the UART byte-to-word controller between uart_rx and the RL core.

---
 rtl/uart_frame_assembler_pkg.sv | 17 +
 rtl/uart_frame_assembler_timeout.sv | 33 +++
 rtl/uart_frame_assembler.sv | 155 +++++++++++++++
 tb/tb_uart_frame_assembler.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_assembler_pkg.sv
// Shared types and constants for the UART frame assembler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_CHKSUM  = 2'b10;

  localparam logic [7:0] DEFAULT_HDR = 8'hAA;

endpackage

// File: rtl/uart_frame_assembler_timeout.sv
// Inter-byte watchdog: flags when TIMEOUT_CYC enabled cycles pass without a clear.
// Latency: expire is combinational in the cycle the count would reach TIMEOUT_CYC.
// Backpressure: none; clear has priority, so a byte in the expiry cycle suppresses expire.
module byte_timeout_cnt #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

  logic [W-1:0] cnt;

  // cnt holds the number of full idle cycles already elapsed since the last clear
  assign expire = enable && !clear && (cnt == LAST);

  // count enabled cycles since last clear, holding once expired
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !expire) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Assembles uart_rx bytes into header/payload/checksum frames and presents payload as one flat bus.
// Latency: data_out/frame_valid/frame_cnt update 1 cycle after the last byte's uart_rx_done.
// Backpressure: none; accepts one byte per cycle, HDR may follow a commit with no dead cycle.
module uart_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter int         WORD_W      = 32,
  parameter int         N_WORDS     = 1,
  parameter logic [7:0] HDR         = DEFAULT_HDR,
  parameter bit         CHK_EN      = 1'b1,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic                       uart_rx_done,
  input  logic [7:0]                 uart_rx_data,
  output logic [N_WORDS*WORD_W-1:0]  data_out,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic [15:0]                frame_cnt,
  output logic                       busy
);

  localparam int TOT  = N_WORDS * WORD_W;
  localparam int NB   = TOT / 8;
  localparam int IDXW = $clog2(NB + 1);

  state_t           state, state_nxt;
  logic [IDXW-1:0]  byte_idx;
  logic [7:0]       sum;
  logic [TOT-1:0]   shadow, shadow_nxt, commit_src, commit_dat;
  logic             last_byte, commit, err_set, expire, tmr_clear;
  logic [1:0]       err_nxt;

  assign busy       = (state != IDLE);
  assign last_byte  = (byte_idx == IDXW'(NB - 1));
  // first byte ends up at the top of shadow; shift form also covers the single-byte frame
  assign shadow_nxt = (shadow << 8) | TOT'(uart_rx_data);
  assign tmr_clear  = uart_rx_done || !busy;

  byte_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clear  (tmr_clear),
    .enable (busy),
    .expire (expire)
  );

  // reorder shadow words so word 0 (received first) lands in the low bits of data_out;
  // without a checksum the last byte is still in flight, so commit from the shifted value
  always_comb begin
    commit_dat = '0;
    commit_src = (state == CHECK) ? shadow : shadow_nxt;
    for (int i = 0; i < N_WORDS; i++) begin
      commit_dat[WORD_W*i +: WORD_W] = commit_src[WORD_W*(N_WORDS-1-i) +: WORD_W];
    end
  end

  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and commit/error decisions; a byte always beats the timeout
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    err_set   = 1'b0;
    err_nxt   = ERR_TIMEOUT;
    case (state)
      IDLE: begin
        if (uart_rx_done && (uart_rx_data == HDR)) begin
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (uart_rx_done) begin
          if (last_byte) begin
            if (CHK_EN) begin
              state_nxt = CHECK;
            end else begin
              commit    = 1'b1;
              state_nxt = IDLE;
            end
          end
        end else if (expire) begin
          err_set   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        if (uart_rx_done) begin
          state_nxt = IDLE;
          if (uart_rx_data == sum) begin
            commit = 1'b1;
          end else begin
            err_set = 1'b1;
            err_nxt = ERR_CHKSUM;
          end
        end else if (expire) begin
          err_set   = 1'b1;
          err_nxt   = ERR_TIMEOUT;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // payload capture: shadow shift, running checksum and byte index
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      byte_idx <= '0;
      sum      <= '0;
      shadow   <= '0;
    end else if (state == IDLE) begin
      byte_idx <= '0;
      sum      <= '0;
    end else if ((state == PAYLOAD) && uart_rx_done) begin
      shadow   <= shadow_nxt;
      sum      <= sum + uart_rx_data;
      byte_idx <= last_byte ? '0 : byte_idx + IDXW'(1);
    end
  end

  // output registers: whole-frame commit, strobes, sticky error cause, good-frame count
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_out    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'b00;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= commit;
      frame_err   <= err_set;
      if (err_set) begin
        err_code <= err_nxt;
      end
      if (commit) begin
        data_out  <= commit_dat;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Self-checking bench: scoreboard of expected frames/errors checked as the DUTs produce them.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_frame_assembler;

  typedef struct {
    logic [31:0] dat;
    logic [15:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 1 x 32-bit word, checksum, short timeout
  logic        done_a = 1'b0;
  logic [7:0]  dat_a  = 8'h00;
  logic [31:0] out_a;
  logic        fv_a, fe_a, busy_a;
  logic [1:0]  ec_a;
  logic [15:0] cnt_a;

  // DUT B: 2 x 16-bit words, no checksum
  logic        done_b = 1'b0;
  logic [7:0]  dat_b  = 8'h00;
  logic [31:0] out_b;
  logic        fv_b, fe_b, busy_b;
  logic [1:0]  ec_b;
  logic [15:0] cnt_b;

  uart_frame_assembler #(
    .WORD_W(32), .N_WORDS(1), .HDR(8'hAA), .CHK_EN(1'b1), .TIMEOUT_CYC(100)
  ) dut_a (
    .sys_clk(clk), .sys_rst(rst), .uart_rx_done(done_a), .uart_rx_data(dat_a),
    .data_out(out_a), .frame_valid(fv_a), .frame_err(fe_a), .err_code(ec_a),
    .frame_cnt(cnt_a), .busy(busy_a)
  );

  uart_frame_assembler #(
    .WORD_W(16), .N_WORDS(2), .HDR(8'hAA), .CHK_EN(1'b0), .TIMEOUT_CYC(100)
  ) dut_b (
    .sys_clk(clk), .sys_rst(rst), .uart_rx_done(done_b), .uart_rx_data(dat_b),
    .data_out(out_b), .frame_valid(fv_b), .frame_err(fe_b), .err_code(ec_b),
    .frame_cnt(cnt_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  exp_t        exp_a[$];
  exp_t        exp_b[$];
  logic [1:0]  experr_a[$];
  logic [15:0] model_cnt_a = 16'd0;
  logic [15:0] model_cnt_b = 16'd0;
  logic [31:0] last_a = 32'd0;
  logic [15:0] last_cnt_a = 16'd0;
  exp_t        ea, eb;
  logic [1:0]  ee;

  // scoreboard for DUT A: frames and errors
  always @(negedge clk) begin
    if (!rst) begin
      if (fv_a) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_frame got data %h cnt %0d", out_a, cnt_a);
        end else begin
          ea = exp_a.pop_front();
          if (out_a !== ea.dat || cnt_a !== ea.cnt || fe_a !== 1'b0) begin
            errors++;
            $display("FAIL a_frame got data %h cnt %0d err %b, want data %h cnt %0d err 0",
                     out_a, cnt_a, fe_a, ea.dat, ea.cnt);
          end
          last_a     = ea.dat;
          last_cnt_a = ea.cnt;
        end
      end
      if (fe_a) begin
        checks++;
        if (experr_a.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_err got code %b", ec_a);
        end else begin
          ee = experr_a.pop_front();
          if (ec_a !== ee || out_a !== last_a || cnt_a !== last_cnt_a || fv_a !== 1'b0) begin
            errors++;
            $display("FAIL a_err got code %b data %h cnt %0d valid %b, want code %b data %h cnt %0d valid 0",
                     ec_a, out_a, cnt_a, fv_a, ee, last_a, last_cnt_a);
          end
        end
      end
    end
  end

  // scoreboard for DUT B: frames only; any error is unexpected
  always @(negedge clk) begin
    if (!rst) begin
      if (fv_b) begin
        checks++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_frame got data %h cnt %0d", out_b, cnt_b);
        end else begin
          eb = exp_b.pop_front();
          if (out_b !== eb.dat || cnt_b !== eb.cnt) begin
            errors++;
            $display("FAIL b_frame got data %h cnt %0d, want data %h cnt %0d",
                     out_b, cnt_b, eb.dat, eb.cnt);
          end
        end
      end
      if (fe_b) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_err got code %b", ec_b);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // caller is at a negedge; strobe lasts exactly one cycle, consecutive calls are back-to-back
  task automatic send_a(input logic [7:0] b);
    dat_a  = b;
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    dat_b  = b;
    done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
  endtask

  task automatic push_a(input logic [31:0] d);
    model_cnt_a = model_cnt_a + 16'd1;
    exp_a.push_back('{dat: d, cnt: model_cnt_a});
  endtask

  task automatic push_b(input logic [31:0] d);
    model_cnt_b = model_cnt_b + 16'd1;
    exp_b.push_back('{dat: d, cnt: model_cnt_b});
  endtask

  task automatic frame_a(input logic [31:0] d, input bit good, input int gap);
    logic [7:0] s;
    s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    if (good) push_a(d);
    else      experr_a.push_back(2'b10);
    send_a(8'hAA);     idle(gap);
    send_a(d[31:24]);  idle(gap);
    send_a(d[23:16]);  idle(gap);
    send_a(d[15:8]);   idle(gap);
    send_a(d[7:0]);    idle(gap);
    send_a(good ? s : s + 8'd1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_a.size() != 0 || experr_a.size() != 0 || exp_b.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_a.size() != 0 || experr_a.size() != 0 || exp_b.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending a=%0d aerr=%0d b=%0d, want all 0",
               name, exp_a.size(), experr_a.size(), exp_b.size());
      exp_a.delete();
      experr_a.delete();
      exp_b.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    checks++;
    if (out_a !== 32'd0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL reset_a_data got %h cnt %0d, want 0 0", out_a, cnt_a);
    end
    checks++;
    if ({fv_a, fe_a, ec_a, busy_a} !== 5'd0) begin
      errors++;
      $display("FAIL reset_a_flags got %b, want 00000", {fv_a, fe_a, ec_a, busy_a});
    end
    checks++;
    if (out_b !== 32'd0 || cnt_b !== 16'd0 || {fv_b, fe_b, ec_b, busy_b} !== 5'd0) begin
      errors++;
      $display("FAIL reset_b got data %h cnt %0d flags %b, want all 0",
               out_b, cnt_b, {fv_b, fe_b, ec_b, busy_b});
    end
    rst = 1'b0;
    idle(2);
    checks++;
    if (busy_a !== 1'b0 || cnt_a !== 16'd0) begin
      errors++;
      $display("FAIL post_reset got busy %b cnt %0d, want 0 0", busy_a, cnt_a);
    end
  endtask

  task automatic test_good_frame();
    frame_a(32'h12345678, 1'b1, 0);
    checks++;
    if (fv_a !== 1'b1) begin
      errors++;
      $display("FAIL good_latency got frame_valid %b, want 1", fv_a);
    end
    @(negedge clk);
    checks++;
    if (fv_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL good_pulse got frame_valid %b busy %b, want 0 0", fv_a, busy_a);
    end
    drain("good");
  endtask

  task automatic test_timeout();
    experr_a.push_back(2'b01);
    send_a(8'hAA);
    send_a(8'h12);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL timeout_busy got %b, want 1", busy_a);
    end
    idle(99);
    checks++;
    if (fe_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early got err %b busy %b, want 0 1", fe_a, busy_a);
    end
    idle(1);
    checks++;
    if (fe_a !== 1'b1 || busy_a !== 1'b0 || ec_a !== 2'b01) begin
      errors++;
      $display("FAIL timeout_fire got err %b busy %b code %b, want 1 0 01", fe_a, busy_a, ec_a);
    end
    drain("timeout");
    // a byte in the expiry cycle keeps the frame alive
    push_a(32'h12345679);
    send_a(8'hAA);
    send_a(8'h12);
    idle(99);
    send_a(8'h34);
    send_a(8'h56);
    send_a(8'h79);
    send_a(8'h15);
    drain("timeout_edge");
  endtask

  task automatic test_bad_checksum();
    checks++;
    if (ec_a !== 2'b01) begin
      errors++;
      $display("FAIL chk_prev_code got %b, want 01", ec_a);
    end
    frame_a(32'h12345678, 1'b0, 1);
    drain("chksum");
    checks++;
    if (ec_a !== 2'b10 || out_a !== 32'h12345679 || cnt_a !== 16'd2) begin
      errors++;
      $display("FAIL chk_hold got code %b data %h cnt %0d, want 10 12345679 2", ec_a, out_a, cnt_a);
    end
  endtask

  task automatic test_sync();
    push_a(32'hAA000001);
    send_a(8'h55);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("FAIL sync_junk got busy %b, want 0", busy_a);
    end
    send_a(8'h00);
    send_a(8'hAA);
    send_a(8'hAA);
    send_a(8'h00);
    send_a(8'h00);
    send_a(8'h01);
    send_a(8'hAB);
    drain("sync");
  endtask

  task automatic test_back_to_back();
    frame_a(32'hDEADBEEF, 1'b1, 0);
    frame_a(32'h00FF0102, 1'b1, 0);
    push_b(32'h03040102);
    push_b(32'h07080506);
    send_b(8'hAA);
    send_b(8'h01);
    send_b(8'h02);
    send_b(8'h03);
    send_b(8'h04);
    checks++;
    if (out_b[15:0] !== 16'h0102 || out_b[31:16] !== 16'h0304) begin
      errors++;
      $display("FAIL b2b_words got w0 %h w1 %h, want 0102 0304", out_b[15:0], out_b[31:16]);
    end
    send_b(8'hAA);
    send_b(8'h05);
    send_b(8'h06);
    send_b(8'h07);
    send_b(8'h08);
    drain("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      frame_a($urandom(), ($urandom_range(0, 3) != 0), $urandom_range(0, 5));
    end
    drain("random");
  endtask

  task automatic test_reset_midframe();
    send_a(8'hAA);
    send_a(8'h12);
    send_a(8'h34);
    send_b(8'hAA);
    send_b(8'h01);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_a !== 32'd0 || cnt_a !== 16'd0 || busy_a !== 1'b0 || ec_a !== 2'b00) begin
      errors++;
      $display("FAIL midrst_a got data %h cnt %0d busy %b code %b, want 0 0 0 00",
               out_a, cnt_a, busy_a, ec_a);
    end
    checks++;
    if (out_b !== 32'd0 || cnt_b !== 16'd0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL midrst_b got data %h cnt %0d busy %b, want 0 0 0", out_b, cnt_b, busy_b);
    end
    model_cnt_a = 16'd0;
    model_cnt_b = 16'd0;
    last_a      = 32'd0;
    last_cnt_a  = 16'd0;
    rst = 1'b0;
    idle(2);
    frame_a(32'hCAFE0042, 1'b1, 0);
    drain("midrst");
    checks++;
    if (cnt_a !== 16'd1 || out_a !== 32'hCAFE0042) begin
      errors++;
      $display("FAIL midrst_after got cnt %0d data %h, want 1 cafe0042", cnt_a, out_a);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_timeout();
    test_bad_checksum();
    test_sync();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
